// File: rtl/fft_pkg.sv
// Shared FFT result-path types: frame geometry defaults, complex bin layout,
// magnitude width and the peak-detector state encoding.
package fft_pkg;
  localparam int FFT_M     = 9;
  localparam int FFT_WIDTH = 16;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } complex_t;

  typedef logic [2*FFT_WIDTH-1:0] mag_t;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} peak_state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// |X|^2 pipeline: S1 registers the bin, S2 registers both signed squares,
// S3 (combinational here) sums them; the consumer registers the result.
module fft_mag_sq #(
  parameter int M     = 9,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [2*WIDTH-1:0] i_data,
  input  logic [M-1:0]       i_idx,
  output logic               o_valid,
  output logic [M-1:0]       o_idx,
  output logic [2*WIDTH-1:0] o_mag,
  output logic               o_busy
);
  logic [1:0]               r_vld_pipe;
  logic signed [WIDTH-1:0]  r_re, r_im;
  logic [M-1:0]             r_idx1, r_idx2;
  logic signed [2*WIDTH-1:0] r_re_sq, r_im_sq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_re       <= '0;
      r_im       <= '0;
      r_idx1     <= '0;
      r_idx2     <= '0;
      r_re_sq    <= '0;
      r_im_sq    <= '0;
    end else begin
      r_vld_pipe <= i_flush ? 2'b00 : {r_vld_pipe[0], i_valid};
      r_re       <= i_data[2*WIDTH-1:WIDTH];
      r_im       <= i_data[WIDTH-1:0];
      r_idx1     <= i_idx;
      // Full 2W-bit signed product keeps (-2^(W-1))^2 = 2^(2W-2) exact.
      r_re_sq    <= r_re * r_re;
      r_im_sq    <= r_im * r_im;
      r_idx2     <= r_idx1;
    end
  end

  // Both squares are non-negative and <= 2^(2W-2), so the sum fits unsigned 2W.
  assign o_mag   = $unsigned(r_re_sq) + $unsigned(r_im_sq);
  assign o_valid = r_vld_pipe[1];
  assign o_idx   = r_idx2;
  assign o_busy  = |r_vld_pipe;
endmodule

// File: rtl/fft_peak_detect.sv
// Tracks the strongest bin of the lower half-spectrum of each FFT frame and
// reports its index and |X|^2 one cycle after the pipeline drains.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int M       = FFT_M,
  parameter int WIDTH   = FFT_WIDTH,
  parameter int SKIP_DC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               busy,
  output logic               done,
  output logic [M-1:0]       peak_bin,
  output logic [2*WIDTH-1:0] peak_mag
);
  localparam logic [M-1:0] LO   = M'(SKIP_DC != 0);
  localparam logic [M-1:0] LAST = '1;

  peak_state_t        r_state, w_state_nxt;
  logic [M-1:0]       r_cnt, r_max_idx;
  logic [2*WIDTH-1:0] r_max;
  logic               w_accept, w_upd, w_mvalid, w_pipe_busy;
  logic [M-1:0]       w_midx;
  logic [2*WIDTH-1:0] w_mag;

  // A sample arriving with start belongs to the aborted frame and is dropped.
  assign w_accept = in_valid && (r_state == ACCUM) && !start;

  fft_mag_sq #(.M(M), .WIDTH(WIDTH)) u_mag_sq (
    .clk     (clk),
    .reset   (reset),
    .i_flush (start),
    .i_valid (w_accept),
    .i_data  (in_data),
    .i_idx   (r_cnt),
    .o_valid (w_mvalid),
    .o_idx   (w_midx),
    .o_mag   (w_mag),
    .o_busy  (w_pipe_busy)
  );

  // Window [LO, N/2-1]: upper half-spectrum has its MSB set.
  assign w_upd = w_mvalid && !w_midx[M-1] && ((SKIP_DC == 0) || (w_midx != '0))
                 && (w_mag > r_max);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = IDLE;
      ACCUM:   if (w_accept && r_cnt == LAST) w_state_nxt = FLUSH;
      FLUSH:   if (!w_pipe_busy) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (start) w_state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_max     <= '0;
      r_max_idx <= LO;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_cnt     <= '0;
        r_max     <= '0;
        r_max_idx <= LO;
      end else begin
        if (w_accept) r_cnt <= r_cnt + 1'b1;
        if (w_upd) begin
          r_max     <= w_mag;
          r_max_idx <= w_midx;
        end
      end
      if (w_state_nxt == DONE) begin
        peak_bin <= r_max_idx;
        peak_mag <= r_max;
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
endmodule
